pmf_pipe_fu: RTL and testbench

//  Parametrised, pipelined integer add/sub functional unit for the Tomasulo core. Takes operands

---
 rtl/pmf_pkg.sv | 30 +++
 rtl/pmf_pipe_stage.sv | 49 ++++
 rtl/pmf_pipe_fu.sv | 128 ++++++++++++
 tb/tb_pmf_pipe_fu.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmf_pkg.sv
// pmf_pkg -- shared definitions for the pipelined add/sub functional unit.
//   Op encodings, default widths/latency, and the payload width helper used
//   by the unit, the reservation station and the CDB arbiter.
//   Optional feature macro: PMF_OVERFLOW_EN (adds one overflow bit to the payload).
package pmf_pkg;

  localparam int PMF_WIDTH_DEF   = 32;
  localparam int PMF_TAG_W_DEF   = 4;
  localparam int PMF_LATENCY_DEF = 2;
  localparam int PMF_OP_W        = 2;

  typedef enum logic [PMF_OP_W-1:0] {
    PMF_OP_ADD = 2'b00,
    PMF_OP_SUB = 2'b01,
    PMF_OP_SLT = 2'b10,
    PMF_OP_RSV = 2'b11
  } pmf_op_e;

`ifdef PMF_OVERFLOW_EN
  localparam int PMF_OVF_W = 1;
`else
  localparam int PMF_OVF_W = 0;
`endif

  // Payload layout, MSB first: [ovf (optional)] [result] [tag]
  function automatic int pmf_payload_w(input int width, input int tag_w);
    return width + tag_w + PMF_OVF_W;
  endfunction

endpackage

// File: rtl/pmf_pipe_stage.sv
// pmf_pipe_stage -- one valid/payload register stage of the functional unit.
//   clk        clock
//   RST        synchronous reset, active-high; clears valid and payload
//   flush      drops the held op at the next edge
//   up_valid   upstream offers a payload
//   up_payload payload from upstream
//   dn_ready   downstream can take this stage's payload this cycle
//   dn_valid   this stage holds a payload
//   dn_payload held payload
module pmf_pipe_stage
  import pmf_pkg::*;
#(
  parameter int PW = 36
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [PW-1:0] up_payload,
  input  logic          dn_ready,
  output logic          dn_valid,
  output logic [PW-1:0] dn_payload
);

  logic          valid_reg;
  logic [PW-1:0] payload_reg;
  logic          take;

  // The stage can load whenever it is empty or its content leaves this edge.
  assign take = !valid_reg || dn_ready;

  always_ff @(posedge clk) begin
    if (RST) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
    end else if (flush) begin
      valid_reg   <= 1'b0;
    end else if (take) begin
      valid_reg <= up_valid;
      if (up_valid) begin
        payload_reg <= up_payload;
      end
    end
  end

  assign dn_valid   = valid_reg;
  assign dn_payload = payload_reg;

endmodule

// File: rtl/pmf_pipe_fu.sv
// pmf_pipe_fu -- pipelined integer ADD/SUB/SLT unit feeding the CDB.
//   Result is computed combinationally ahead of stage 0 and then carried with
//   its tag through LATENCY register stages; the last stage is the head that
//   waits for the CDB grant.
//   clk/RST     clock, synchronous active-high reset
//   flush       mispredict: drop every in-flight op
//   in_valid/in_ready, in_op, in_a, in_b, in_tag   issue handshake and operands
//   out_valid/out_ack, out_result, out_tag          head result and CDB grant
//   out_ovf     signed overflow flag (only with PMF_OVERFLOW_EN defined)
//   busy        any stage holds an op
module pmf_pipe_fu
  import pmf_pkg::*;
#(
  parameter int WIDTH   = PMF_WIDTH_DEF,
  parameter int TAG_W   = PMF_TAG_W_DEF,
  parameter int LATENCY = PMF_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
`ifdef PMF_OVERFLOW_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int PW = pmf_payload_w(WIDTH, TAG_W);

  logic [WIDTH-1:0]   res_next;
  logic [PW-1:0]      pay_in;
  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] up_rdy;
  logic [PW-1:0]      stage_pay [LATENCY];
  logic               full_tail;

  // Stage-0 compute. SUB is a + ~b + 1 so carry-out simply falls off the top.
  always_comb begin
    res_next = '0;
    case (pmf_op_e'(in_op))
      PMF_OP_ADD: res_next = in_a + in_b;
      PMF_OP_SUB: res_next = in_a + ~in_b + WIDTH'(1);
      PMF_OP_SLT: res_next = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default:    res_next = '0;
    endcase
  end

`ifdef PMF_OVERFLOW_EN
  logic ovf_next;

  // Signed overflow: ADD needs equal operand signs, SUB needs differing ones,
  // and in both cases the result sign must differ from operand A.
  always_comb begin
    ovf_next = 1'b0;
    case (pmf_op_e'(in_op))
      PMF_OP_ADD: ovf_next = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_next[WIDTH-1] != in_a[WIDTH-1]);
      PMF_OP_SUB: ovf_next = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res_next[WIDTH-1] != in_a[WIDTH-1]);
      default:    ovf_next = 1'b0;
    endcase
  end

  assign pay_in  = {ovf_next, res_next, in_tag};
  assign out_ovf = stage_pay[LATENCY-1][PW-1];
`else
  assign pay_in = {res_next, in_tag};
`endif

  // Stage i can take new data unless it and every stage after it are full
  // and the head is not being granted. Built from valids only, so the
  // ready path has no combinational chain through the stages themselves.
  always_comb begin
    full_tail = 1'b1;
    up_rdy    = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      full_tail = full_tail & stage_valid[i];
      up_rdy[i] = out_ack | ~full_tail;
    end
  end

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic          s_up_valid;
      logic [PW-1:0] s_up_pay;
      logic          s_dn_ready;

      if (gi == 0) begin : g_first
        assign s_up_valid = in_valid && !flush;
        assign s_up_pay   = pay_in;
      end else begin : g_mid
        assign s_up_valid = stage_valid[gi-1];
        assign s_up_pay   = stage_pay[gi-1];
      end

      if (gi == LATENCY - 1) begin : g_head
        assign s_dn_ready = out_ack;
      end else begin : g_body
        assign s_dn_ready = up_rdy[gi+1];
      end

      pmf_pipe_stage #(.PW(PW)) u_stage (
        .clk       (clk),
        .RST       (RST),
        .flush     (flush),
        .up_valid  (s_up_valid),
        .up_payload(s_up_pay),
        .dn_ready  (s_dn_ready),
        .dn_valid  (stage_valid[gi]),
        .dn_payload(stage_pay[gi])
      );
    end
  endgenerate

  assign in_ready   = up_rdy[0] && !flush;
  assign out_valid  = stage_valid[LATENCY-1];
  assign out_result = stage_pay[LATENCY-1][TAG_W +: WIDTH];
  assign out_tag    = stage_pay[LATENCY-1][TAG_W-1:0];
  assign busy       = |stage_valid;

endmodule

// File: tb/tb_pmf_pipe_fu.sv
// tb_pmf_pipe_fu -- scoreboard bench for pmf_pipe_fu (WIDTH=32, TAG_W=4, LATENCY=2).
//   Accepted ops push their expected result into a queue; a monitor compares
//   the head output against the queue front. Also honours PMF_OVERFLOW_EN.
module tb_pmf_pipe_fu;

  localparam int WIDTH   = 32;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 2;

  logic             clk;
  logic             RST;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ack;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef PMF_OVERFLOW_EN
  logic             out_ovf;
`endif

  pmf_pipe_fu #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_result(out_result),
    .out_tag   (out_tag),
`ifdef PMF_OVERFLOW_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the op's meaning.
  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint s;
    sa    = longint'($signed(a));
    sb_v  = longint'($signed(b));
    e.tag = tag;
    e.ovf = 1'b0;
    case (op)
      2'd0: begin
        e.res = a + b;
        s     = sa + sb_v;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd1: begin
        e.res = a - b;
        s     = sa - sb_v;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd2:    e.res = (sa < sb_v) ? 32'd1 : 32'd0;
      default: e.res = 32'd0;
    endcase
    return e;
  endfunction

  // Handshake logger: expected in_ready from occupancy, then queue updates.
  always @(posedge clk) begin
    if (RST) begin
      sb.delete();
    end else begin
      check("in_ready", {63'd0, in_ready},
            {63'd0, (!flush && ((sb.size() < LATENCY) || out_ack))});
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ack && sb.size() > 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b, in_tag));
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!RST) begin
      check("busy", {63'd0, busy}, {63'd0, (sb.size() != 0)});
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got tag 0x%0h result 0x%0h, expected no output", out_tag, out_result);
        end else begin
          check("sb_result", {32'd0, out_result}, {32'd0, sb[0].res});
          check("sb_tag", {60'd0, out_tag}, {60'd0, sb[0].tag});
`ifdef PMF_OVERFLOW_EN
          check("sb_ovf", {63'd0, out_ovf}, {63'd0, sb[0].ovf});
`endif
          if (out_ack) $display("retire tag=%0d result=0x%08h", out_tag, out_result);
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op into an empty pipe with out_ack=1 and check the head result.
  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp, input string name);
    logic found;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ack = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check({name, "_valid"}, {63'd0, found}, 64'd1);
    if (found) check(name, {32'd0, out_result}, {32'd0, exp});
  endtask

  int   exp_tag;
  int   acc;
  logic acc_flag;

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_a = '0; in_b = '0; in_tag = '0; out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Test 1: exact latency and single-cycle output with out_ack=1
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd5; in_b = 32'd7; in_tag = 4'd3; out_ack = 1'b1;
    @(negedge clk);
    check("t1_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < LATENCY - 1; k++) begin
      @(negedge clk);
      check("t1_early_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_result", {32'd0, out_result}, 64'd12);
    check("t1_tag", {60'd0, out_tag}, 64'd3);
    @(negedge clk);
    check("t1_one_cycle", {63'd0, out_valid}, 64'd0);

    // Test 2: op coverage
    run_op(2'd1, 32'd3, 32'd5, 4'd1, 32'hFFFF_FFFE, "t2_sub");
    run_op(2'd2, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, "t2_slt_neg");
    run_op(2'd2, 32'd1, 32'hFFFF_FFFF, 4'd4, 32'd0, "t2_slt_pos");
    run_op(2'd3, 32'd7, 32'd9, 4'd5, 32'd0, "t2_rsv");
`ifdef PMF_OVERFLOW_EN
    run_op(2'd0, 32'h7FFF_FFFF, 32'd1, 4'd6, 32'h8000_0000, "t6_add_ovf");
    check("t6_add_ovf_flag", {63'd0, out_ovf}, 64'd1);
    run_op(2'd1, 32'h8000_0000, 32'd1, 4'd7, 32'h7FFF_FFFF, "t6_sub_ovf");
    check("t6_sub_ovf_flag", {63'd0, out_ovf}, 64'd1);
    run_op(2'd0, 32'd1, 32'd2, 4'd8, 32'd3, "t6_add_noovf");
    check("t6_noovf_flag", {63'd0, out_ovf}, 64'd0);
`endif
    repeat (2) @(posedge clk);

    // Test 3: stream tags 0..7 under back-pressure, then release
    #1;
    out_ack = 1'b0; in_valid = 1'b1; in_op = 2'd0; in_a = $urandom; in_b = $urandom; in_tag = 4'd0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc_flag = in_ready;
      @(posedge clk); #1;
      if (acc_flag) begin
        acc++;
        in_tag = 4'(acc); in_a = $urandom; in_b = $urandom;
      end
    end
    check("t3_accepts_stalled", acc, LATENCY);
    @(negedge clk);
    check("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ack = 1'b1;
    exp_tag = 0;
    for (int c = 0; c < 40 && exp_tag < 8; c++) begin
      @(negedge clk);
      acc_flag = in_ready && in_valid;
      if (out_valid) begin
        check("t3_order", {60'd0, out_tag}, 64'(exp_tag));
        exp_tag++;
      end
      @(posedge clk); #1;
      if (acc_flag) begin
        acc++;
        if (acc >= 8) in_valid = 1'b0;
        else begin in_tag = 4'(acc); in_a = $urandom; in_b = $urandom; end
      end
    end
    in_valid = 1'b0;
    check("t3_count", exp_tag, 8);

    // Test 4: flush with a full pipe and an op offered
    @(posedge clk); #1;
    out_ack = 1'b0; in_valid = 1'b1; in_op = 2'd1; in_a = 32'd100; in_b = 32'd1; in_tag = 4'd9;
    repeat (LATENCY + 2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("t4_in_ready", {63'd0, in_ready}, 64'd0);
    check("t4_busy_before", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t4_out_valid", {63'd0, out_valid}, 64'd0);
    check("t4_busy", {63'd0, busy}, 64'd0);

    // Test 5: reset with two ops in flight
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'h1234; in_b = 32'h1111; in_tag = 4'hA;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_before", {63'd0, busy}, 64'd1);
    @(posedge clk); #1 RST = 1'b1;
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    check("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check("t5_out_result", {32'd0, out_result}, 64'd0);
    check("t5_out_tag", {60'd0, out_tag}, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);

    // Random phase
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 2'($urandom_range(0, 3));
      in_a     = pick();
      in_b     = pick();
      in_tag   = 4'($urandom);
      out_ack  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 49) == 0);
    end

    // Drain
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ack = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
